// File: rtl/cluster_pe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cluster_pe_ctrl_if
// Desc     : Point-stream handshake between a point source and cluster_pe_ctrl.
// Revision : 1.0
// ============================================================================
interface cluster_pe_ctrl_if #(
  parameter int CENTER_SIZE = 24
) ();
  logic                   point_valid;
  logic                   point_ready;
  logic [CENTER_SIZE-1:0] point_data;

  modport master (
    output point_valid,
    output point_data,
    input  point_ready
  );

  modport slave (
    input  point_valid,
    input  point_data,
    output point_ready
  );
endinterface
`default_nettype wire

// File: rtl/cluster_pe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cluster_pe_ctrl
// Desc     : Iteration sequencer for a kd-tree clustering PE array. Defining
//            CLUSTER_PE_CTRL_SORT_EARLY_EXIT_EN ends sorting after a quiet pass.
// Revision : 1.0
// ============================================================================
module cluster_pe_ctrl #(
  parameter  int DIM         = 3,
  parameter  int DATA_RANGE  = 255,
  parameter  int MAX_DEPTH   = 16,
  localparam int DIM_SIZE    = $clog2(DATA_RANGE),
  localparam int DEPTH_SIZE  = $clog2(MAX_DEPTH),
  localparam int CENTER_SIZE = DIM * DIM_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [15:0]            i_num_points,
  input  logic [7:0]             i_max_iter,
  input  logic [DEPTH_SIZE-1:0]  i_tree_depth,
  cluster_pe_ctrl_if.slave       pt,
  input  logic                   i_pe_stable,
  input  logic                   i_pe_switch_any,
  output logic                   o_en,
  output logic                   o_init,
  output logic                   o_start_iter,
  output logic                   o_receive_point,
  output logic                   o_inc,
  output logic                   o_update,
  output logic                   o_sorting,
  output logic                   o_parent_switch,
  output logic                   o_child_switch,
  output logic                   o_next_level,
  output logic [CENTER_SIZE-1:0] o_point_out,
  output logic [DEPTH_SIZE-1:0]  o_depth_out,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [7:0]             o_iter_count
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_INIT       = 4'd1,
    S_START_ITER = 4'd2,
    S_WAIT_PT    = 4'd3,
    S_RECEIVE    = 4'd4,
    S_DESCEND    = 4'd5,
    S_INC        = 4'd6,
    S_UPDATE     = 4'd7,
    S_SORT_P     = 4'd8,
    S_SORT_C     = 4'd9,
    S_CHECK      = 4'd10,
    S_DONE       = 4'd11
  } state_t;

  typedef struct packed {
    logic en;
    logic busy;
    logic init;
    logic start_iter;
    logic receive_point;
    logic inc;
    logic update;
    logic sorting;
    logic parent_switch;
    logic child_switch;
    logic next_level;
    logic point_ready;
    logic done;
  } strobe_t;

  // Strobes are registered alongside the state, so they are a pure
  // function of the state being entered.
  function automatic strobe_t f_strobes(input state_t s);
    strobe_t v;
    v      = '0;
    v.en   = (s != S_IDLE);
    v.busy = (s != S_IDLE);
    case (s)
      S_INIT:       v.init          = 1'b1;
      S_START_ITER: v.start_iter    = 1'b1;
      S_WAIT_PT:    v.point_ready   = 1'b1;
      S_RECEIVE: begin
        v.receive_point = 1'b1;
        v.next_level    = 1'b1;
      end
      S_DESCEND:    v.next_level    = 1'b1;
      S_INC:        v.inc           = 1'b1;
      S_UPDATE:     v.update        = 1'b1;
      S_SORT_P: begin
        v.sorting       = 1'b1;
        v.parent_switch = 1'b1;
      end
      S_SORT_C: begin
        v.sorting      = 1'b1;
        v.child_switch = 1'b1;
      end
      S_DONE:       v.done          = 1'b1;
      default:      ;
    endcase
    return v;
  endfunction

  state_t                r_state;
  strobe_t               r_strb;
  logic [CENTER_SIZE-1:0] r_point;
  logic [DEPTH_SIZE-1:0] r_depth;
  logic [7:0]            r_iter;
  logic [15:0]           r_pt_cnt;
  logic [DEPTH_SIZE-1:0] r_lvl;
  logic [DEPTH_SIZE:0]   r_pass;

  logic [DEPTH_SIZE:0]   w_passes;
  logic [DEPTH_SIZE:0]   w_pass_nxt;
  logic [8:0]            w_iter_nxt;
  logic [8:0]            w_max_iter;
  logic [16:0]           w_pt_nxt;
  logic                  w_sort_last;

  // Zero depth and zero iteration limit both behave as one.
  assign w_passes   = (r_depth == '0) ? {{DEPTH_SIZE{1'b0}}, 1'b1} : {1'b0, r_depth};
  assign w_pass_nxt = r_pass + 1'b1;
  assign w_iter_nxt = {1'b0, r_iter} + 9'd1;
  assign w_max_iter = (i_max_iter == 8'd0) ? 9'd1 : {1'b0, i_max_iter};
  assign w_pt_nxt   = {1'b0, r_pt_cnt} + 17'd1;

`ifdef CLUSTER_PE_CTRL_SORT_EARLY_EXIT_EN
  logic r_sw_p;
  assign w_sort_last = (w_pass_nxt >= w_passes) || (!r_sw_p && !i_pe_switch_any);
`else
  logic w_unused_switch;
  assign w_unused_switch = i_pe_switch_any;
  assign w_sort_last     = (w_pass_nxt >= w_passes);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_strb   <= '0;
      r_point  <= '0;
      r_depth  <= '0;
      r_iter   <= '0;
      r_pt_cnt <= '0;
      r_lvl    <= '0;
      r_pass   <= '0;
`ifdef CLUSTER_PE_CTRL_SORT_EARLY_EXIT_EN
      r_sw_p   <= 1'b0;
`endif
    end else if (i_abort && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
      r_strb  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state  <= S_INIT;
            r_strb   <= f_strobes(S_INIT);
            r_depth  <= i_tree_depth;
            r_iter   <= '0;
            r_pt_cnt <= '0;
          end
        end
        S_INIT: begin
          r_state  <= S_START_ITER;
          r_strb   <= f_strobes(S_START_ITER);
          r_pt_cnt <= '0;
        end
        S_START_ITER: begin
          r_pt_cnt <= '0;
          if (i_num_points == 16'd0) begin
            r_state <= S_UPDATE;
            r_strb  <= f_strobes(S_UPDATE);
          end else begin
            r_state <= S_WAIT_PT;
            r_strb  <= f_strobes(S_WAIT_PT);
          end
        end
        S_WAIT_PT: begin
          if (pt.point_valid) begin
            r_point <= pt.point_data;
            r_lvl   <= {{(DEPTH_SIZE-1){1'b0}}, 1'b1};
            r_state <= S_RECEIVE;
            r_strb  <= f_strobes(S_RECEIVE);
          end
        end
        S_RECEIVE: begin
          if (r_depth > {{(DEPTH_SIZE-1){1'b0}}, 1'b1}) begin
            r_lvl   <= r_lvl + 1'b1;
            r_state <= S_DESCEND;
            r_strb  <= f_strobes(S_DESCEND);
          end else begin
            r_state <= S_INC;
            r_strb  <= f_strobes(S_INC);
          end
        end
        S_DESCEND: begin
          if (r_lvl == r_depth) begin
            r_state <= S_INC;
            r_strb  <= f_strobes(S_INC);
          end else begin
            r_lvl <= r_lvl + 1'b1;
          end
        end
        S_INC: begin
          r_pt_cnt <= w_pt_nxt[15:0];
          if (w_pt_nxt == {1'b0, i_num_points}) begin
            r_state <= S_UPDATE;
            r_strb  <= f_strobes(S_UPDATE);
          end else begin
            r_state <= S_WAIT_PT;
            r_strb  <= f_strobes(S_WAIT_PT);
          end
        end
        S_UPDATE: begin
          r_pass  <= '0;
          r_state <= S_SORT_P;
          r_strb  <= f_strobes(S_SORT_P);
        end
        S_SORT_P: begin
`ifdef CLUSTER_PE_CTRL_SORT_EARLY_EXIT_EN
          r_sw_p  <= i_pe_switch_any;
`endif
          r_state <= S_SORT_C;
          r_strb  <= f_strobes(S_SORT_C);
        end
        S_SORT_C: begin
          r_pass <= w_pass_nxt;
          if (w_sort_last) begin
            r_state <= S_CHECK;
            r_strb  <= f_strobes(S_CHECK);
          end else begin
            r_state <= S_SORT_P;
            r_strb  <= f_strobes(S_SORT_P);
          end
        end
        S_CHECK: begin
          if (i_pe_stable || (w_iter_nxt >= w_max_iter)) begin
            r_state <= S_DONE;
            r_strb  <= f_strobes(S_DONE);
          end else begin
            r_iter  <= w_iter_nxt[7:0];
            r_state <= S_START_ITER;
            r_strb  <= f_strobes(S_START_ITER);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_strb  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_strb  <= '0;
        end
      endcase
    end
  end

  assign o_en            = r_strb.en;
  assign o_busy          = r_strb.busy;
  assign o_init          = r_strb.init;
  assign o_start_iter    = r_strb.start_iter;
  assign o_receive_point = r_strb.receive_point;
  assign o_inc           = r_strb.inc;
  assign o_update        = r_strb.update;
  assign o_sorting       = r_strb.sorting;
  assign o_parent_switch = r_strb.parent_switch;
  assign o_child_switch  = r_strb.child_switch;
  assign o_next_level    = r_strb.next_level;
  assign o_done          = r_strb.done;
  assign pt.point_ready  = r_strb.point_ready;
  assign o_point_out     = r_point;
  assign o_depth_out     = r_depth;
  assign o_iter_count    = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_cluster_pe_ctrl.sv
`default_nettype none
// Bench for cluster_pe_ctrl: a loop-structured reference model predicts every
// output each cycle; directed runs pin pulse counts with literal values.
module tb_cluster_pe_ctrl;
  localparam int CS = 24;
  localparam int DS = 4;

  localparam int B_EN = 12, B_BUSY = 11, B_INIT = 10, B_SI = 9, B_RX = 8, B_INC = 7;
  localparam int B_UPD = 6, B_SORT = 5, B_PS = 4, B_CSW = 3, B_NL = 2, B_PR = 1, B_DONE = 0;

  localparam logic [12:0] P_BASE  = (13'd1 << B_EN) | (13'd1 << B_BUSY);
  localparam logic [12:0] P_INIT  = P_BASE | (13'd1 << B_INIT);
  localparam logic [12:0] P_START = P_BASE | (13'd1 << B_SI);
  localparam logic [12:0] P_WAIT  = P_BASE | (13'd1 << B_PR);
  localparam logic [12:0] P_RECV  = P_BASE | (13'd1 << B_RX) | (13'd1 << B_NL);
  localparam logic [12:0] P_DESC  = P_BASE | (13'd1 << B_NL);
  localparam logic [12:0] P_INC   = P_BASE | (13'd1 << B_INC);
  localparam logic [12:0] P_UPD   = P_BASE | (13'd1 << B_UPD);
  localparam logic [12:0] P_SP    = P_BASE | (13'd1 << B_SORT) | (13'd1 << B_PS);
  localparam logic [12:0] P_SC    = P_BASE | (13'd1 << B_SORT) | (13'd1 << B_CSW);
  localparam logic [12:0] P_CHK   = P_BASE;
  localparam logic [12:0] P_DONE  = P_BASE | (13'd1 << B_DONE);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0, abort = 1'b0, pe_stable = 1'b0, pe_switch_any = 1'b0;
  logic [15:0]   num_points = '0;
  logic [7:0]    max_iter = '0;
  logic [DS-1:0] tree_depth = '0;

  logic o_en, o_init, o_start_iter, o_receive_point, o_inc, o_update, o_sorting;
  logic o_parent_switch, o_child_switch, o_next_level, o_busy, o_done;
  logic [CS-1:0] o_point_out;
  logic [DS-1:0] o_depth_out;
  logic [7:0]    o_iter_count;

  cluster_pe_ctrl_if #(.CENTER_SIZE(CS)) pt_if ();

  cluster_pe_ctrl dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .i_num_points(num_points), .i_max_iter(max_iter), .i_tree_depth(tree_depth),
    .pt(pt_if), .i_pe_stable(pe_stable), .i_pe_switch_any(pe_switch_any),
    .o_en(o_en), .o_init(o_init), .o_start_iter(o_start_iter),
    .o_receive_point(o_receive_point), .o_inc(o_inc), .o_update(o_update),
    .o_sorting(o_sorting), .o_parent_switch(o_parent_switch),
    .o_child_switch(o_child_switch), .o_next_level(o_next_level),
    .o_point_out(o_point_out), .o_depth_out(o_depth_out), .o_busy(o_busy),
    .o_done(o_done), .o_iter_count(o_iter_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cnt[13];
  int snap_c[13];

  // ---------------- reference model ----------------
  logic [12:0]   m_exp;
  logic [CS-1:0] m_point;
  logic [DS-1:0] m_depth;
  logic [7:0]    m_iter;
  bit            m_ab;

  // One controller cycle showing pattern p; the following edge may abort it.
  task automatic seg(input logic [12:0] p);
    m_exp = p;
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_ab = 1'b1; m_point = '0; m_depth = '0; m_iter = '0;
    end else if (abort) begin
      m_ab = 1'b1;
    end
  endtask

  task automatic run_model();
    int nlev;
`ifdef CLUSTER_PE_CTRL_SORT_EARLY_EXIT_EN
    bit sw_p, sw_c;
`endif
    m_depth = tree_depth;
    m_iter  = '0;
    nlev    = (tree_depth == '0) ? 1 : int'(tree_depth);
    seg(P_INIT); if (m_ab) return;
    forever begin
      seg(P_START); if (m_ab) return;
      for (int p = 0; p < int'(num_points); p++) begin
        do begin
          seg(P_WAIT); if (m_ab) return;
        end while (!pt_if.point_valid);
        m_point = pt_if.point_data;
        for (int l = 0; l < nlev; l++) begin
          seg((l == 0) ? P_RECV : P_DESC); if (m_ab) return;
        end
        seg(P_INC); if (m_ab) return;
      end
      seg(P_UPD); if (m_ab) return;
      for (int s = 0; s < nlev; s++) begin
        seg(P_SP); if (m_ab) return;
`ifdef CLUSTER_PE_CTRL_SORT_EARLY_EXIT_EN
        sw_p = pe_switch_any;
`endif
        seg(P_SC); if (m_ab) return;
`ifdef CLUSTER_PE_CTRL_SORT_EARLY_EXIT_EN
        sw_c = pe_switch_any;
        if (!sw_p && !sw_c) break;
`endif
      end
      seg(P_CHK); if (m_ab) return;
      if (pe_stable || (int'(m_iter) + 1 >= ((max_iter == 8'd0) ? 1 : int'(max_iter)))) break;
      m_iter = m_iter + 8'd1;
    end
    seg(P_DONE);
  endtask

  initial begin : model
    m_point = '0; m_depth = '0; m_iter = '0;
    forever begin
      m_exp = '0;
      m_ab  = 1'b0;
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_point = '0; m_depth = '0; m_iter = '0;
      end else if (start) begin
        run_model();
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    logic [12:0] act;
    foreach (cnt[i]) cnt[i] = 0;
    forever begin
      @(negedge clk);
      act = {o_en, o_busy, o_init, o_start_iter, o_receive_point, o_inc, o_update,
             o_sorting, o_parent_switch, o_child_switch, o_next_level,
             pt_if.point_ready, o_done};
      for (int b = 0; b < 13; b++) if (act[b]) cnt[b]++;
      n_vec++;
      if (act !== m_exp || o_point_out !== m_point || o_depth_out !== m_depth ||
          o_iter_count !== m_iter) begin
        n_err++;
        $display("FAIL cycle t=%0t strobes got %b want %b point got %h want %h depth got %0d want %0d iter got %0d want %0d",
                 $time, act, m_exp, o_point_out, m_point, o_depth_out, m_depth, o_iter_count, m_iter);
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rnd = 1'b0;
  bit rnd_abort = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rnd) begin
      pt_if.point_valid = 1'($urandom_range(0, 1));
      pt_if.point_data  = CS'($urandom);
      pe_stable         = ($urandom_range(0, 3) == 0);
      pe_switch_any     = 1'($urandom_range(0, 1));
      abort             = rnd_abort && ($urandom_range(0, 79) == 0);
    end
  endtask

  task automatic do_reset();
    tick(); #2 rst = 1'b0;
    tick(); tick(); #2 rst = 1'b1;
  endtask

  task automatic snap();
    foreach (cnt[i]) snap_c[i] = cnt[i];
  endtask

  function automatic int d(input int b);
    return cnt[b] - snap_c[b];
  endfunction

  task automatic launch(input int dep, input int np, input int mi);
    tree_depth = DS'(dep);
    num_points = 16'(np);
    max_iter   = 8'(mi);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (o_busy && k < 2000) begin tick(); k++; end
    if (o_busy) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout: busy still 1 after %0d cycles, want 0", nm, k);
      do_reset();
    end
    tick(); tick();
  endtask

  task automatic wait_for(input string nm, input int which);
    int k;
    bit hit;
    k = 0;
    hit = 1'b0;
    while (!hit && k < 60) begin
      case (which)
        0: hit = o_next_level && !o_receive_point;
        1: hit = o_child_switch;
        default: hit = pt_if.point_ready;
      endcase
      if (!hit) begin tick(); k++; end
    end
    if (!hit) begin
      n_vec++; n_err++;
      $display("FAIL %s timeout after %0d cycles", nm, k);
    end
  endtask

  initial begin : main
    pt_if.point_valid = 1'b0;
    pt_if.point_data  = '0;
    tick(); tick();
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_point_out", int'(o_point_out), 0);
    chk("reset_iter", int'(o_iter_count), 0);
    #2 rst = 1'b1;
    tick();

    // Full run with depth 3, two points, single iteration
    pt_if.point_valid = 1'b1; pt_if.point_data = 24'h123456;
    pe_stable = 1'b0; pe_switch_any = 1'b1;
    snap(); launch(3, 2, 1); wait_idle("run_basic");
    chk("basic_init", d(B_INIT), 1);
    chk("basic_start_iter", d(B_SI), 1);
    chk("basic_receive", d(B_RX), 2);
    chk("basic_next_level", d(B_NL), 6);
    chk("basic_inc", d(B_INC), 2);
    chk("basic_update", d(B_UPD), 1);
    chk("basic_parent", d(B_PS), 3);
    chk("basic_child", d(B_CSW), 3);
    chk("basic_done", d(B_DONE), 1);
    chk("basic_iter", int'(o_iter_count), 0);
    chk("basic_depth_out", int'(o_depth_out), 3);
    chk("basic_point_out", int'(o_point_out), 32'h123456);

    // No points: straight to UPDATE
    snap(); launch(2, 0, 1); wait_idle("run_nopts");
    chk("nopts_receive", d(B_RX), 0);
    chk("nopts_inc", d(B_INC), 0);
    chk("nopts_update", d(B_UPD), 1);
    chk("nopts_done", d(B_DONE), 1);

    // Iteration limit and early stability
    pe_stable = 1'b0;
    snap(); launch(1, 1, 4); wait_idle("run_iter4");
    chk("iter4_start_iter", d(B_SI), 4);
    chk("iter4_iter", int'(o_iter_count), 3);
    pe_stable = 1'b1;
    snap(); launch(1, 1, 4); wait_idle("run_stable");
    chk("stable_start_iter", d(B_SI), 1);
    chk("stable_iter", int'(o_iter_count), 0);
    snap(); launch(0, 1, 0); wait_idle("run_maxiter0");
    chk("maxiter0_start_iter", d(B_SI), 1);
    chk("maxiter0_next_level", d(B_NL), 1);
    pe_stable = 1'b0;

    // Point source stalls for five cycles
    pt_if.point_valid = 1'b0;
    launch(1, 1, 1);
    wait_for("stall_wait_ready", 2);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", int'(pt_if.point_ready), 1);
      chk("stall_strobes", int'(o_init | o_start_iter | o_receive_point | o_inc | o_update |
                                o_sorting | o_next_level | o_done), 0);
      tick();
    end
    pt_if.point_valid = 1'b1; pt_if.point_data = 24'hFFFFFF;
    tick();
    pt_if.point_valid = 1'b0;
    wait_idle("run_stall");
    chk("stall_point_out", int'(o_point_out), 32'hFFFFFF);

    // Abort in DESCEND, then reset in SORT_C
    pt_if.point_valid = 1'b1; pt_if.point_data = 24'h00A5A5;
    snap(); launch(5, 1, 1);
    wait_for("abort_wait_descend", 0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_next_level", int'(o_next_level), 0);
    tick(); tick();
    chk("abort_done", d(B_DONE), 0);
    chk("abort_point_held", int'(o_point_out), 32'h00A5A5);
    snap(); launch(2, 1, 1);
    wait_for("rst_wait_sortc", 1);
    #2 rst = 1'b0;
    tick();
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_point_out", int'(o_point_out), 0);
    tick(); #2 rst = 1'b1;
    tick();
    chk("rst_done", d(B_DONE), 0);
    snap(); launch(3, 2, 1); wait_idle("run_after_rst");
    chk("after_rst_init", d(B_INIT), 1);
    chk("after_rst_done", d(B_DONE), 1);

    // Quiet sort passes
    pe_switch_any = 1'b0; pe_stable = 1'b1;
    snap(); launch(4, 1, 1); wait_idle("run_quiet_sort");
`ifdef CLUSTER_PE_CTRL_SORT_EARLY_EXIT_EN
    chk("quiet_sort_passes", d(B_PS), 1);
`else
    chk("quiet_sort_passes", d(B_PS), 4);
`endif

    // Randomized runs with sporadic aborts and resets
    rnd = 1'b1; rnd_abort = 1'b1;
    for (int i = 0; i < 40; i++) begin
      launch(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      if (i % 8 == 7) begin
        repeat ($urandom_range(3, 30)) tick();
        do_reset();
      end
      wait_idle("run_random");
    end
    rnd = 1'b0; rnd_abort = 1'b0; abort = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
